// File: rtl/batalha_pkg.sv
// -----------------------------------------------------------------------------
// batalha_pkg
// Shared definitions for the ship placement validator:
//   - tipo encodings and ship length table (TIPO_LEN)
//   - hidroaviao cell offset table (hidro_off)
//   - validator FSM state enum
//   - BOARD_CELLS: cells per board for the default 8x8 geometry
// -----------------------------------------------------------------------------
package batalha_pkg;

    localparam int BOARD_CELLS = 64;

    typedef enum logic [2:0] {
        SUBMARINO    = 3'd0,
        CRUZADOR     = 3'd1,
        HIDROAVIAO   = 3'd2,
        ENCOURACADO  = 3'd3,
        PORTA_AVIOES = 3'd4
    } tipo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2,
        WRITE = 2'd3
    } estado_t;

    // Ship length indexed by tipo
    localparam logic [2:0] TIPO_LEN [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    // Illegal codes map to length 1; they never reach CHECK/WRITE anyway.
    function automatic logic [2:0] tipo_len(input logic [2:0] t);
        logic [2:0] r;
        r = 3'd1;
        if (t <= 3'd4) begin
            r = TIPO_LEN[t];
        end
        return r;
    endfunction

    // Hidroaviao offsets {dx, dy}, each a 3-bit two's-complement value.
    // Rows by rotation: 0:(0,0)(1,1)(2,0)  1:(0,0)(1,1)(0,2)
    //                   2:(0,0)(-1,1)(0,2) 3:(0,0)(1,-1)(2,0)
    function automatic logic [5:0] hidro_off(input logic [1:0] ori, input logic [1:0] k);
        logic [5:0] r;
        r = 6'b000_000;
        case ({ori, k})
            4'b00_01: r = {3'd1,   3'd1};
            4'b00_10: r = {3'd2,   3'd0};
            4'b01_01: r = {3'd1,   3'd1};
            4'b01_10: r = {3'd0,   3'd2};
            4'b10_01: r = {3'b111, 3'd1};
            4'b10_10: r = {3'd0,   3'd2};
            4'b11_01: r = {3'd1,   3'b111};
            4'b11_10: r = {3'd2,   3'd0};
            default:  r = 6'b000_000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/celula_gen.sv
// -----------------------------------------------------------------------------
// celula_gen
// Combinational coordinate generator for cell k of a ship.
//   tipo, direcao, ori (rotation, low 2 bits), x1, y1, k  -> cx, cy, fora
//   fora = 1 when the cell lies outside the 2^COORD_W x 2^COORD_W board.
// -----------------------------------------------------------------------------
module celula_gen
    import batalha_pkg::*;
#(
    parameter int COORD_W = 3
) (
    input  logic [2:0]         tipo,
    input  logic               direcao,
    input  logic [1:0]         ori,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [2:0]         k,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               fora
);
    localparam int SW = COORD_W + 1;

    logic [5:0]           h_off;
    logic signed [2:0]    h_dx;
    logic signed [2:0]    h_dy;
    logic signed [SW-1:0] dx;
    logic signed [SW-1:0] dy;
    logic signed [SW-1:0] sx;
    logic signed [SW-1:0] sy;

    assign h_off = hidro_off(ori, k[1:0]);
    assign h_dx  = h_off[5:3];
    assign h_dy  = h_off[2:0];

    always_comb begin
        dx = '0;
        dy = '0;
        if (tipo == HIDROAVIAO) begin
            dx = SW'(h_dx);
            dy = SW'(h_dy);
        end else if (direcao) begin
            dy = SW'(k);
        end else begin
            dx = SW'(k);
        end
    end

    assign sx = $signed({1'b0, x1}) + dx;
    assign sy = $signed({1'b0, y1}) + dy;

    // Reachable results span -1 .. 2^COORD_W+3; every out-of-range value
    // (negative or >= 2^COORD_W) has the top bit of the extended sum set.
    assign fora = sx[SW-1] | sy[SW-1];
    assign cx   = sx[COORD_W-1:0];
    assign cy   = sy[COORD_W-1:0];

endmodule

// File: rtl/validador_posicao.sv
// -----------------------------------------------------------------------------
// validador_posicao
// Validates a candidate ship against the per-player occupancy board and, on
// the falling edge of valida after a clean check, commits it.
//   clk, reset (async, active-low)
//   valida            : rise starts a check, fall commits (clean) or aborts
//   tipo, jogador, X1, Y1, direcao, orientacao : candidate ship
//   limpa             : synchronous clear of both boards and counters
//   rd_jogador, rd_x, rd_y -> rd_ocupado : combinational read port
//   conflito, busy, done : check status
//   celulas0, celulas1   : saturating occupied-cell counts per player
// Build option: define ADJACENCY_CHECK_EN to also reject ships touching
// existing ones (8-neighbourhood of every cell).
// -----------------------------------------------------------------------------
module validador_posicao
    import batalha_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valida,
    input  logic [2:0]         tipo,
    input  logic               jogador,
    input  logic [COORD_W-1:0] X1,
    input  logic [COORD_W-1:0] Y1,
    input  logic               direcao,
    input  logic [2:0]         orientacao,
    input  logic               limpa,
    input  logic               rd_jogador,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic               conflito,
    output logic               busy,
    output logic               done,
    output logic               rd_ocupado,
    output logic [CNT_W-1:0]   celulas0,
    output logic [CNT_W-1:0]   celulas1
);
    localparam int NCELL = 1 << (2 * COORD_W);
    localparam int SW    = COORD_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    estado_t            state_reg, state_next;
    logic [2:0]         k_reg, k_next;
    logic               conflito_reg, conflito_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               valida_prev_reg;

    logic [2:0]         tipo_reg;
    logic               jog_reg;
    logic [COORD_W-1:0] x1_reg, y1_reg;
    logic               dir_reg;
    logic [2:0]         ori_reg;

    logic               lat_load, wr_en, clear;
    logic               illegal_in, cell_bad, adj_hit, fora;
    logic [2:0]         last_k;
    logic [COORD_W-1:0] cx, cy;
    logic [2*COORD_W-1:0] cell_idx;
    logic [NCELL-1:0]   board [2];
    logic [CNT_W-1:0]   cnt [2];
    logic [NCELL-1:0]   board_cur;

    celula_gen #(.COORD_W(COORD_W)) u_celula_gen (
        .tipo    (tipo_reg),
        .direcao (dir_reg),
        .ori     (ori_reg[1:0]),
        .x1      (x1_reg),
        .y1      (y1_reg),
        .k       (k_reg),
        .cx      (cx),
        .cy      (cy),
        .fora    (fora)
    );

    assign cell_idx  = {cy, cx};
    assign board_cur = board[jog_reg];
    assign last_k    = tipo_len(tipo_reg) - 3'd1;
    // Rotation 4 aliases rotation 0 through the low two bits; 5-7 are rejected.
    assign illegal_in = (tipo > 3'd4) || ((tipo == HIDROAVIAO) && (orientacao > 3'd4));

`ifdef ADJACENCY_CHECK_EN
    // All 9 board reads are combinational, so check latency stays one cycle per cell.
    logic [8:0] viz_hit;
    for (genvar gi = 0; gi < 9; gi++) begin : g_viz
        localparam int DX = (gi % 3) - 1;
        localparam int DY = (gi / 3) - 1;
        logic signed [SW-1:0] nx;
        logic signed [SW-1:0] ny;
        assign nx = $signed({1'b0, cx}) + SW'(DX);
        assign ny = $signed({1'b0, cy}) + SW'(DY);
        assign viz_hit[gi] = !nx[SW-1] && !ny[SW-1] &&
                             board_cur[{ny[COORD_W-1:0], nx[COORD_W-1:0]}];
    end
    assign adj_hit = |viz_hit;
`else
    assign adj_hit = 1'b0;
`endif

    assign cell_bad = fora || board_cur[cell_idx] || adj_hit;

    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        conflito_next = conflito_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        lat_load      = 1'b0;
        wr_en         = 1'b0;
        clear         = 1'b0;
        if (limpa) begin
            clear         = 1'b1;
            state_next    = IDLE;
            k_next        = 3'd0;
            conflito_next = 1'b0;
            busy_next     = 1'b0;
            done_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valida && !valida_prev_reg) begin
                        lat_load = 1'b1;
                        k_next   = 3'd0;
                        if (illegal_in) begin
                            state_next    = DONE;
                            conflito_next = 1'b1;
                            busy_next     = 1'b0;
                            done_next     = 1'b1;
                        end else begin
                            state_next    = CHECK;
                            conflito_next = 1'b0;
                            busy_next     = 1'b1;
                            done_next     = 1'b0;
                        end
                    end
                end
                CHECK: begin
                    if (!valida) begin
                        // Placement withdrawn mid-check: report failure, write nothing.
                        state_next    = IDLE;
                        conflito_next = 1'b1;
                        busy_next     = 1'b0;
                    end else if (cell_bad) begin
                        state_next    = DONE;
                        conflito_next = 1'b1;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end else if (k_reg == last_k) begin
                        state_next    = DONE;
                        conflito_next = 1'b0;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        k_next = k_reg + 3'd1;
                    end
                end
                DONE: begin
                    if (!valida) begin
                        done_next = 1'b0;
                        k_next    = 3'd0;
                        if (!conflito_reg) begin
                            state_next = WRITE;
                            busy_next  = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                WRITE: begin
                    wr_en = 1'b1;
                    if (k_reg == last_k) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end else begin
                        k_next = k_reg + 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            k_reg           <= 3'd0;
            conflito_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            valida_prev_reg <= 1'b0;
            tipo_reg        <= 3'd0;
            jog_reg         <= 1'b0;
            x1_reg          <= '0;
            y1_reg          <= '0;
            dir_reg         <= 1'b0;
            ori_reg         <= 3'd0;
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            conflito_reg    <= conflito_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            valida_prev_reg <= valida;
            if (lat_load) begin
                tipo_reg <= tipo;
                jog_reg  <= jogador;
                x1_reg   <= X1;
                y1_reg   <= Y1;
                dir_reg  <= direcao;
                ori_reg  <= orientacao;
            end
        end
    end

    // One occupancy board and saturating counter per player
    for (genvar gi = 0; gi < 2; gi++) begin : g_jog
        logic [NCELL-1:0] board_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic             wr_sel;

        assign wr_sel = wr_en && (jog_reg == 1'(gi));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                board_reg <= '0;
                cnt_reg   <= '0;
            end else if (clear) begin
                board_reg <= '0;
                cnt_reg   <= '0;
            end else if (wr_sel) begin
                board_reg[cell_idx] <= 1'b1;
                if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        assign board[gi] = board_reg;
        assign cnt[gi]   = cnt_reg;
    end

    assign conflito   = conflito_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign rd_ocupado = board[rd_jogador][{rd_y, rd_x}];
    assign celulas0   = cnt[0];
    assign celulas1   = cnt[1];

endmodule

// File: tb/tb_validador_posicao.sv
module tb_validador_posicao;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       valida     = 1'b0;
    logic [2:0] tipo       = 3'd0;
    logic       jogador    = 1'b0;
    logic [2:0] X1         = 3'd0;
    logic [2:0] Y1         = 3'd0;
    logic       direcao    = 1'b0;
    logic [2:0] orientacao = 3'd0;
    logic       limpa      = 1'b0;
    logic       rd_jogador = 1'b0;
    logic [2:0] rd_x       = 3'd0;
    logic [2:0] rd_y       = 3'd0;
    logic       conflito, busy, done, rd_ocupado;
    logic [4:0] celulas0, celulas1;

    int total = 0;
    int bad   = 0;

    // Reference model: occupancy per player [jogador][x][y], saturating counts
    bit mb [2][8][8];
    int mcnt [2];
    int m_conf, m_lat, m_len;
    int m_cx [5];
    int m_cy [5];
    int obs_lat;
    logic obs_conf;

    int HDX [4][3] = '{'{0, 1, 2}, '{0, 1, 0}, '{0, -1, 0}, '{0, 1, 2}};
    int HDY [4][3] = '{'{0, 1, 0}, '{0, 1, 2}, '{0, 1, 2}, '{0, -1, 0}};

    validador_posicao dut (
        .clk        (clk),
        .reset      (reset),
        .valida     (valida),
        .tipo       (tipo),
        .jogador    (jogador),
        .X1         (X1),
        .Y1         (Y1),
        .direcao    (direcao),
        .orientacao (orientacao),
        .limpa      (limpa),
        .rd_jogador (rd_jogador),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .conflito   (conflito),
        .busy       (busy),
        .done       (done),
        .rd_ocupado (rd_ocupado),
        .celulas0   (celulas0),
        .celulas1   (celulas1)
    );

    always #5 clk = ~clk;

    function automatic int occ(int j, int x, int y);
        if (x < 0 || x > 7 || y < 0 || y > 7) return 0;
        return mb[j][x][y] ? 1 : 0;
    endfunction

    // Expected outcome: conflict flag, check latency (cells examined), cell list
    function automatic void model_eval(int t, int j, int x, int y, int d, int o);
        bit bad_cell;
        m_conf = 0; m_lat = 0; m_len = 0;
        if (t > 4 || (t == 2 && o > 4)) begin
            m_conf = 1;
            return;
        end
        m_len = t + 1;
        for (int k = 0; k < m_len; k++) begin
            if (t == 2) begin
                m_cx[k] = x + HDX[o % 4][k];
                m_cy[k] = y + HDY[o % 4][k];
            end else begin
                m_cx[k] = x + (d != 0 ? 0 : k);
                m_cy[k] = y + (d != 0 ? k : 0);
            end
        end
        for (int k = 0; k < m_len; k++) begin
            bad_cell = (m_cx[k] < 0 || m_cx[k] > 7 || m_cy[k] < 0 || m_cy[k] > 7) ||
                       (occ(j, m_cx[k], m_cy[k]) != 0);
`ifdef ADJACENCY_CHECK_EN
            for (int ddx = -1; ddx <= 1; ddx++)
                for (int ddy = -1; ddy <= 1; ddy++)
                    if (occ(j, m_cx[k] + ddx, m_cy[k] + ddy) != 0) bad_cell = 1'b1;
`endif
            if (bad_cell) begin
                m_conf = 1;
                m_lat  = k + 1;
                return;
            end
        end
        m_lat = m_len;
    endfunction

    function automatic void model_commit(int j);
        for (int k = 0; k < m_len; k++) begin
            mb[j][m_cx[k]][m_cy[k]] = 1'b1;
            if (mcnt[j] < 31) mcnt[j]++;
        end
    endfunction

    function automatic void model_clear();
        for (int j = 0; j < 2; j++) begin
            mcnt[j] = 0;
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    mb[j][x][y] = 1'b0;
        end
    endfunction

    task automatic check_boards(input string tag);
        logic [63:0] got, expv;
        logic [4:0]  cgot;
        for (int j = 0; j < 2; j++) begin
            got = '0; expv = '0;
            for (int y = 0; y < 8; y++) begin
                for (int x = 0; x < 8; x++) begin
                    @(negedge clk);
                    rd_jogador = j[0]; rd_x = 3'(x); rd_y = 3'(y);
                    #1;
                    got[y*8+x]  = rd_ocupado;
                    expv[y*8+x] = mb[j][x][y];
                end
            end
            total++;
            if (got !== expv) begin
                bad++;
                $display("FAIL board%0d %s: got=%h expected=%h", j, tag, got, expv);
            end
            cgot = (j == 0) ? celulas0 : celulas1;
            total++;
            if (cgot !== 5'(mcnt[j])) begin
                bad++;
                $display("FAIL celulas%0d %s: got=%0d expected=%0d", j, tag, cgot, mcnt[j]);
            end
        end
    endtask

    task automatic do_limpa();
        @(negedge clk);
        limpa = 1'b1;
        @(negedge clk);
        limpa = 1'b0;
        model_clear();
    endtask

    // Full transaction: raise valida, wait done, hold, drop, wait write end
    task automatic do_place(input int t, input int j, input int x, input int y,
                            input int d, input int o, input string tag);
        int   cyc, nbusy;
        logic busy_first;
        model_eval(t, j, x, y, d, o);
        @(negedge clk);
        tipo = 3'(t); jogador = j[0]; X1 = 3'(x); Y1 = 3'(y);
        direcao = d[0]; orientacao = 3'(o);
        valida = 1'b1;
        cyc = 0; busy_first = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy_first = busy;
        end while (done !== 1'b1 && cyc < 12);
        obs_lat  = cyc - 1;
        obs_conf = conflito;
        total++;
        if (done !== 1'b1 || obs_lat != m_lat) begin
            bad++;
            $display("FAIL latency %s: done=%b cycles=%0d expected=%0d", tag, done, obs_lat, m_lat);
        end
        total++;
        if (conflito !== (m_conf != 0)) begin
            bad++;
            $display("FAIL conflito %s: got=%b expected=%0d", tag, conflito, m_conf);
        end
        total++;
        if (busy_first !== (m_len != 0)) begin
            bad++;
            $display("FAIL busy_check %s: got=%b expected=%b", tag, busy_first, (m_len != 0));
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_hold %s: done=%b busy=%b expected done=1 busy=0", tag, done, busy);
        end
        valida = 1'b0;
        cyc = 0; nbusy = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) nbusy++;
        end while (busy !== 1'b0 && cyc < 12);
        total++;
        if (nbusy != (m_conf != 0 ? 0 : m_len)) begin
            bad++;
            $display("FAIL write_cycles %s: got=%0d expected=%0d", tag, nbusy, (m_conf != 0 ? 0 : m_len));
        end
        if (m_conf == 0) model_commit(j);
        total++;
        if (conflito !== (m_conf != 0) || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_state %s: conflito=%b done=%b expected conflito=%0d done=0", tag, conflito, done, m_conf);
        end
        check_boards(tag);
        $display("place %s tipo=%0d jog=%0d (%0d,%0d) dir=%0d ori=%0d conflito=%b lat=%0d", tag, t, j, x, y, d, o, obs_conf, obs_lat);
    endtask

    task automatic test_reset();
        model_clear();
        #3;
        total++;
        if (conflito !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_ocupado !== 1'b0 ||
            celulas0 !== 5'd0 || celulas1 !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: conflito=%b busy=%b done=%b rd=%b c0=%0d c1=%0d expected all 0",
                     conflito, busy, done, rd_ocupado, celulas0, celulas1);
        end
        check_boards("reset");
        @(negedge clk);
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_submarino();
        do_limpa();
        do_place(0, 0, 3, 3, 0, 0, "submarino");
        total++;
        if (obs_lat != 1 || obs_conf !== 1'b0 || celulas0 !== 5'd1) begin
            bad++;
            $display("FAIL submarino_const: lat=%0d conflito=%b c0=%0d expected 1/0/1", obs_lat, obs_conf, celulas0);
        end
        @(negedge clk);
        rd_jogador = 1'b0; rd_x = 3'd3; rd_y = 3'd3;
        #1;
        total++;
        if (rd_ocupado !== 1'b1) begin
            bad++;
            $display("FAIL rd_033: got=%b expected=1", rd_ocupado);
        end
    endtask

    task automatic test_fora();
        do_limpa();
        do_place(4, 0, 4, 0, 0, 0, "porta_avioes_fora");
        total++;
        if (obs_conf !== 1'b1 || celulas0 !== 5'd0) begin
            bad++;
            $display("FAIL fora_const: conflito=%b c0=%0d expected 1/0", obs_conf, celulas0);
        end
    endtask

    task automatic test_overlap();
        do_limpa();
        do_place(1, 0, 2, 2, 1, 0, "cruzador");
        do_place(3, 0, 0, 3, 0, 0, "encouracado_cruza");
        total++;
`ifdef ADJACENCY_CHECK_EN
        if (obs_conf !== 1'b1 || obs_lat != 2) begin
`else
        if (obs_conf !== 1'b1 || obs_lat != 3) begin
`endif
            bad++;
            $display("FAIL overlap_const: conflito=%b lat=%0d", obs_conf, obs_lat);
        end
    endtask

    task automatic test_hidro();
        do_limpa();
        do_place(2, 0, 0, 0, 0, 2, "hidro_fora");
        total++;
        if (obs_conf !== 1'b1) begin
            bad++;
            $display("FAIL hidro_fora_const: conflito=%b expected 1", obs_conf);
        end
        do_place(2, 0, 1, 0, 0, 2, "hidro_ok");
        total++;
        if (obs_conf !== 1'b0 || celulas0 !== 5'd3) begin
            bad++;
            $display("FAIL hidro_ok_const: conflito=%b c0=%0d expected 0/3", obs_conf, celulas0);
        end
        do_place(2, 1, 4, 4, 0, 4, "hidro_ori4");
        do_place(2, 1, 0, 6, 0, 6, "hidro_ori6_illegal");
        do_place(6, 1, 0, 0, 0, 0, "tipo6_illegal");
    endtask

    task automatic test_abort();
        do_limpa();
        @(negedge clk);
        tipo = 3'd3; jogador = 1'b0; X1 = 3'd0; Y1 = 3'd0; direcao = 1'b0; orientacao = 3'd0;
        valida = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy: got=%b expected=1", busy);
        end
        @(negedge clk);
        valida = 1'b0;
        @(negedge clk);
        total++;
        if (conflito !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: conflito=%b busy=%b done=%b expected 1/0/0", conflito, busy, done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (conflito !== 1'b1) begin
            bad++;
            $display("FAIL abort_hold: conflito=%b expected=1", conflito);
        end
        check_boards("abort");
        $display("abort encouracado done");
    endtask

    task automatic test_limpa_write();
        int cyc;
        do_limpa();
        @(negedge clk);
        tipo = 3'd4; jogador = 1'b1; X1 = 3'd0; Y1 = 3'd0; direcao = 1'b1; orientacao = 3'd0;
        valida = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 12);
        valida = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL limpa_write_busy: got=%b expected=1", busy);
        end
        limpa = 1'b1;
        @(negedge clk);
        limpa = 1'b0;
        model_clear();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || conflito !== 1'b0) begin
            bad++;
            $display("FAIL limpa_write_state: busy=%b done=%b conflito=%b expected 0/0/0", busy, done, conflito);
        end
        check_boards("limpa_write");
        $display("limpa during write done");
    endtask

    task automatic test_adjacency();
        do_limpa();
        do_place(0, 0, 3, 3, 0, 0, "sub_33");
        do_place(0, 0, 4, 4, 0, 0, "sub_44");
        total++;
`ifdef ADJACENCY_CHECK_EN
        if (obs_conf !== 1'b1) begin
`else
        if (obs_conf !== 1'b0) begin
`endif
            bad++;
            $display("FAIL adjacency_const: conflito=%b", obs_conf);
        end
    endtask

    task automatic test_saturation();
`ifndef ADJACENCY_CHECK_EN
        do_limpa();
        for (int y = 0; y < 8; y++) do_place(4, 0, 0, y, 0, 0, "sat_row");
        total++;
        if (celulas0 !== 5'd31) begin
            bad++;
            $display("FAIL saturation: c0=%0d expected=31", celulas0);
        end
`endif
    endtask

    task automatic test_random();
        int t;
        do_limpa();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 11) == 0) do_limpa();
            t = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            do_place(t, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), "random");
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        do_limpa();
        do_place(0, 0, 5, 5, 0, 0, "pre_reset");
        @(negedge clk);
        tipo = 3'd4; jogador = 1'b1; X1 = 3'd0; Y1 = 3'd7; direcao = 1'b0; orientacao = 3'd0;
        valida = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 12);
        valida = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        model_clear();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || conflito !== 1'b0 || celulas0 !== 5'd0 || celulas1 !== 5'd0) begin
            bad++;
            $display("FAIL reset_mid_op: busy=%b done=%b conflito=%b c0=%0d c1=%0d expected all 0",
                     busy, done, conflito, celulas0, celulas1);
        end
        @(negedge clk);
        reset = 1'b1;
        check_boards("reset_mid_op");
        $display("reset mid write done");
    endtask

    initial begin
        test_reset();
        test_submarino();
        test_fora();
        test_overlap();
        test_hidro();
        test_abort();
        test_limpa_write();
        test_adjacency();
        test_saturation();
        test_random();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/validador_posicao.md
Name: validador_posicao

Overview:
- Downstream of the piece-placement FSM. It consumes the candidate ship (tipo, jogador, X1, Y1, direcao, orientacao) while valida is high.
- It walks the ship's cells one per clock, checks board bounds and overlap against the per-player occupancy board, and returns conflito.
- On the falling edge of valida after a clean check, it commits the cells into that player's board.
- Also serves a read port and per-player occupied-cell counts to the game-execution stage.

Parameters:
- COORD_W, 3: coordinate width; board is 2^COORD_W x 2^COORD_W (8x8).
- CNT_W, 5: width of each per-player occupied-cell counter (max 24 cells per fleet).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- valida  in  1  level from placement FSM; rising edge starts a check, falling edge commits or aborts
- tipo  in  3  0 submarino(1 cell), 1 cruzador(2), 2 hidroaviao(3), 3 encouracado(4), 4 porta-avioes(5); 5-7 illegal
- jogador  in  1  target board, 0 or 1
- X1, Y1  in  COORD_W  anchor cell
- direcao  in  1  0 = cells extend along +X, 1 = cells extend along +Y; ignored for hidroaviao
- orientacao  in  3  hidroaviao rotation; value 4 treated as 0; 5-7 illegal for hidroaviao
- limpa  in  1  synchronous clear of both boards and counters
- rd_jogador  in  1  read-port board select
- rd_x, rd_y  in  COORD_W  read-port cell
- conflito  out  1  1 = last check failed
- busy  out  1  check or write in progress
- done  out  1  high from check completion until valida falls
- rd_ocupado  out  1  combinational occupancy of (rd_jogador, rd_x, rd_y)
- celulas0, celulas1  out  CNT_W  occupied-cell counts per player

Behaviour:
- Reset values: all outputs 0, both boards 0, FSM in IDLE.
- Inputs tipo, jogador, X1, Y1, direcao and orientacao are latched on the rising edge of valida and held for the whole operation.
- Cell k, for k = 0 to len-1:
  - Straight ships: (X1+k, Y1) or (X1, Y1+k).
  - Hidroaviao: offset table indexed by orientacao[1:0]:
    - 0: (0,0), (1,1), (2,0)
    - 1: (0,0), (1,1), (0,2)
    - 2: (0,0), (-1,1), (0,2)
    - 3: (0,0), (1,-1), (2,0)
- Coordinate arithmetic is done at COORD_W+1 bits, signed. Any result <0 or >7 is out of bounds.
- FSM states:
  - IDLE: on valida rise, latch inputs, clear conflito, set busy, go to CHECK with k=0. An illegal tipo or orientacao goes straight to DONE with conflito=1.
  - CHECK: one cell per cycle. An out-of-bounds or occupied cell sets conflito=1 and jumps to DONE early. Otherwise, after cell len-1, go to DONE with conflito=0. Latency is at most len cycles.
  - DONE: busy=0, done=1, conflito stable. On valida fall: if conflito=0, go to WRITE; else go to IDLE.
  - WRITE: one cell per cycle; set the board bit and increment that player's counter. After len cycles, go to IDLE with busy=0.
- Boundary rules:
  - valida falls during CHECK: abort, no write, conflito=1, return to IDLE.
  - valida rises again while in WRITE: ignored. The placement FSM only re-raises it after WRITE completes.
  - limpa: highest synchronous priority in any state. Clears boards, counters, conflito and done; returns to IDLE.
  - Counters saturate at 2^CNT_W-1.
  - conflito holds its value in IDLE until the next check starts.
  - Async reset mid-operation discards the operation and clears the boards.

Optional Feature:
- Macro ADJACENCY_CHECK_EN.
- Defined: during CHECK, each cell is also tested against its 8 neighbours on the same board; any occupied in-bounds neighbour gives conflito=1. Out-of-bounds neighbours are ignored. Ships may not touch. Latency is unchanged, because the board is registers and all 9 reads are combinational.
- Undefined: overlap and bounds checks only; touching ships are legal.

Decomposition:
- Package batalha_pkg holds:
  - tipo encodings and the TIPO_LEN table (1, 2, 3, 4, 5)
  - the hidroaviao offset table
  - FSM state enum (IDLE, CHECK, DONE, WRITE)
  - BOARD_CELLS = 64
- Sub-module celula_gen is a combinational block: (tipo, direcao, orientacao, X1, Y1, k) -> (cx, cy, fora).

Test Plan:
- Submarino, jogador 0, (3,3), empty board: conflito=0 and done after 1 cycle. Drop valida: rd_ocupado(0,3,3)=1, celulas0=1.
- Porta-avioes, (4,0), direcao 0: cell X=8 is out of bounds, so conflito=1. Drop valida: board unchanged, celulas0=0.
- Cruzador (2,2) direcao 1 committed; then encouracado (0,3) direcao 0 crosses (2,3): conflito=1 in the 3rd check cycle, done asserts early.
- Hidroaviao, orientacao 2, at (0,0): offset (-1,1) is out of bounds, conflito=1. Same piece at (1,0): conflito=0, cells (1,0), (0,1), (1,2) written.
- valida dropped on the 2nd check cycle of an encouracado: no cells written, conflito=1, FSM returns to IDLE. Next, limpa during WRITE: celulas0=celulas1=0 and all rd_ocupado=0.
- With ADJACENCY_CHECK_EN: submarino at (3,3) committed, then submarino at (4,4) gives conflito=1. Without the macro, conflito=0.
